// File: rtl/run_sequencer.sv
// Harness controller for the 9-bit core: one core reset, then NUM_PROGS start/run/report
// cycles, each measuring Start-release-to-Ack latency under a watchdog.
module run_sequencer #(
  parameter int NUM_PROGS = 3,
  parameter int RESET_CYC = 2,
  parameter int START_CYC = 2,
  parameter int CW        = 16,
  parameter int TIMEOUT   = 50000
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  input  logic          DutAck,
  output logic          DutReset,
  output logic          DutStart,
  output logic [1:0]    ProgIdx,
  output logic          Busy,
  output logic          Done,
  output logic          ResValid,
  input  logic          ResReady,
  output logic [1:0]    ResProg,
  output logic [CW-1:0] ResCycles,
  output logic          ResTimeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_START, S_RUN, S_REPORT, S_DONE
  } state_t;

  localparam int PH_MAX = (RESET_CYC > START_CYC) ? RESET_CYC : START_CYC;
  localparam int PHW    = $clog2(PH_MAX + 1);

  localparam logic [PHW-1:0] RST_LAST  = PHW'(RESET_CYC - 1);
  localparam logic [PHW-1:0] ST_LAST   = PHW'(START_CYC - 1);
  localparam logic [CW-1:0]  TO_VAL    = CW'(TIMEOUT);
  localparam logic [1:0]     LAST_PROG = 2'(NUM_PROGS - 1);

  state_t          r_state, w_state_nxt;
  logic [PHW-1:0]  r_ph, w_ph_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [CW-1:0]   w_cnt_inc;
  logic            r_dut_reset, w_dut_reset_nxt;
  logic            r_dut_start, w_dut_start_nxt;
  logic [1:0]      r_prog_idx, w_prog_idx_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_res_valid, w_res_valid_nxt;
  logic [1:0]      r_res_prog, w_res_prog_nxt;
  logic [CW-1:0]   r_res_cycles, w_res_cycles_nxt;
  logic            r_res_timeout, w_res_timeout_nxt;

  assign w_cnt_inc = r_cnt + CW'(1);

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_ph_nxt          = r_ph;
    w_cnt_nxt         = r_cnt;
    w_dut_reset_nxt   = r_dut_reset;
    w_dut_start_nxt   = r_dut_start;
    w_prog_idx_nxt    = r_prog_idx;
    w_busy_nxt        = r_busy;
    w_done_nxt        = 1'b0;
    w_res_valid_nxt   = r_res_valid;
    w_res_prog_nxt    = r_res_prog;
    w_res_cycles_nxt  = r_res_cycles;
    w_res_timeout_nxt = r_res_timeout;
    case (r_state)
      S_IDLE: begin
        // Core reset is released as soon as the harness itself leaves reset.
        w_dut_reset_nxt = Go;
        if (Go) begin
          w_state_nxt    = S_RST;
          w_busy_nxt     = 1'b1;
          w_ph_nxt       = '0;
          w_prog_idx_nxt = 2'd0;
        end
      end
      S_RST: begin
        if (r_ph == RST_LAST) begin
          w_state_nxt     = S_START;
          w_dut_reset_nxt = 1'b0;
          w_dut_start_nxt = 1'b1;
          w_ph_nxt        = '0;
        end else begin
          w_ph_nxt = r_ph + PHW'(1);
        end
      end
      S_START: begin
        if (r_ph == ST_LAST) begin
          w_state_nxt     = S_RUN;
          w_dut_start_nxt = 1'b0;
          w_cnt_nxt       = '0;
        end else begin
          w_ph_nxt = r_ph + PHW'(1);
        end
      end
      S_RUN: begin
        w_cnt_nxt = w_cnt_inc;
        // r_cnt is zero only in the first RUN cycle, which masks a stale Ack.
        if (DutAck && (r_cnt != '0)) begin
          w_state_nxt       = S_REPORT;
          w_res_valid_nxt   = 1'b1;
          w_res_prog_nxt    = r_prog_idx;
          w_res_cycles_nxt  = w_cnt_inc;
          w_res_timeout_nxt = 1'b0;
        end else if (w_cnt_inc == TO_VAL) begin
          w_state_nxt       = S_REPORT;
          w_res_valid_nxt   = 1'b1;
          w_res_prog_nxt    = r_prog_idx;
          w_res_cycles_nxt  = TO_VAL;
          w_res_timeout_nxt = 1'b1;
        end
      end
      S_REPORT: begin
        if (ResReady) begin
          w_res_valid_nxt = 1'b0;
          if (r_prog_idx < LAST_PROG) begin
            w_prog_idx_nxt  = r_prog_idx + 2'd1;
            w_state_nxt     = S_START;
            w_dut_start_nxt = 1'b1;
            w_ph_nxt        = '0;
          end else begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end
        end
      end
      S_DONE: begin
        w_state_nxt    = S_IDLE;
        w_prog_idx_nxt = 2'd0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ph          <= '0;
      r_cnt         <= '0;
      r_dut_reset   <= 1'b1;
      r_dut_start   <= 1'b0;
      r_prog_idx    <= 2'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_prog    <= 2'd0;
      r_res_cycles  <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      r_ph          <= w_ph_nxt;
      r_cnt         <= w_cnt_nxt;
      r_dut_reset   <= w_dut_reset_nxt;
      r_dut_start   <= w_dut_start_nxt;
      r_prog_idx    <= w_prog_idx_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_res_valid   <= w_res_valid_nxt;
      r_res_prog    <= w_res_prog_nxt;
      r_res_cycles  <= w_res_cycles_nxt;
      r_res_timeout <= w_res_timeout_nxt;
    end
  end

  assign DutReset   = r_dut_reset;
  assign DutStart   = r_dut_start;
  assign ProgIdx    = r_prog_idx;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign ResValid   = r_res_valid;
  assign ResProg    = r_res_prog;
  assign ResCycles  = r_res_cycles;
  assign ResTimeout = r_res_timeout;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: two instances (TIMEOUT 20 and 8) share clock and
// reset; a selector routes stimulus and observation to the instance under test.
module tb_run_sequencer;

  logic        Clk;
  logic        Reset;
  logic [1:0]  go, ack, rdy;
  logic        sel;
  int          n_checks, n_errors;

  logic        rst_a, st_a, busy_a, done_a, vld_a, to_a;
  logic [1:0]  idx_a, prog_a;
  logic [15:0] cyc_a;
  logic        rst_b, st_b, busy_b, done_b, vld_b, to_b;
  logic [1:0]  idx_b, prog_b;
  logic [15:0] cyc_b;

  logic        s_rst, s_start, s_busy, s_done, s_vld, s_to;
  logic [1:0]  s_idx, s_prog;
  logic [15:0] s_cyc;

  run_sequencer #(.NUM_PROGS(3), .RESET_CYC(2), .START_CYC(2), .CW(16), .TIMEOUT(20)) u_dut20 (
    .Clk(Clk), .Reset(Reset), .Go(go[0]), .DutAck(ack[0]),
    .DutReset(rst_a), .DutStart(st_a), .ProgIdx(idx_a), .Busy(busy_a), .Done(done_a),
    .ResValid(vld_a), .ResReady(rdy[0]), .ResProg(prog_a), .ResCycles(cyc_a),
    .ResTimeout(to_a)
  );

  run_sequencer #(.NUM_PROGS(3), .RESET_CYC(2), .START_CYC(2), .CW(16), .TIMEOUT(8)) u_dut8 (
    .Clk(Clk), .Reset(Reset), .Go(go[1]), .DutAck(ack[1]),
    .DutReset(rst_b), .DutStart(st_b), .ProgIdx(idx_b), .Busy(busy_b), .Done(done_b),
    .ResValid(vld_b), .ResReady(rdy[1]), .ResProg(prog_b), .ResCycles(cyc_b),
    .ResTimeout(to_b)
  );

  always_comb begin
    if (sel) begin
      s_rst = rst_b; s_start = st_b; s_busy = busy_b; s_done = done_b;
      s_vld = vld_b; s_to = to_b; s_idx = idx_b; s_prog = prog_b; s_cyc = cyc_b;
    end else begin
      s_rst = rst_a; s_start = st_a; s_busy = busy_a; s_done = done_a;
      s_vld = vld_a; s_to = to_a; s_idx = idx_a; s_prog = prog_a; s_cyc = cyc_a;
    end
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge Clk);
  endtask

  task automatic start_seq;
    int n;
    go[sel] = 1'b1;
    tick;
    go[sel] = 1'b0;
    chk("go_busy", 32'(s_busy), 1);
    chk("go_prog_idx", 32'(s_idx), 0);
    n = 0;
    while (s_rst && n < 20) begin
      tick;
      n++;
    end
    chk("core_rst_len", n, 2);
  endtask

  task automatic run_one(input int exp_prog, input bit pre_ack, input int ack_cyc,
                         input int go_cyc, input int rdy_dly, input int exp_cyc,
                         input bit exp_to);
    int n;
    int rc;
    logic [15:0] hc;
    rdy[sel] = (rdy_dly == 0);
    ack[sel] = pre_ack;
    n = 0;
    while (!s_start && n < 20) begin
      tick;
      n++;
    end
    chk("start_seen", 32'(s_start), 1);
    chk("no_core_rst", 32'(s_rst), 0);
    chk("prog_idx", 32'(s_idx), 32'(exp_prog));
    chk("busy_run", 32'(s_busy), 1);
    n = 0;
    while (s_start && n < 20) begin
      tick;
      n++;
    end
    chk("start_len", n, 2);
    rc = 1;
    while (!s_vld && rc < 200) begin
      ack[sel] = (rc == ack_cyc) || (pre_ack && rc == 1);
      go[sel]  = (rc == go_cyc);
      tick;
      rc++;
    end
    ack[sel] = 1'b0;
    go[sel]  = 1'b0;
    chk("res_valid", 32'(s_vld), 1);
    chk("res_prog", 32'(s_prog), 32'(exp_prog));
    chk("res_cycles", 32'(s_cyc), 32'(exp_cyc));
    chk("res_timeout", 32'(s_to), 32'(exp_to));
    hc = s_cyc;
    for (int i = 0; i < rdy_dly; i++) begin
      tick;
      chk("hold_valid", 32'(s_vld), 1);
      chk("hold_cycles", 32'(s_cyc), 32'(hc));
      chk("hold_prog", 32'(s_prog), 32'(exp_prog));
      chk("hold_no_start", 32'(s_start), 0);
    end
    rdy[sel] = 1'b1;
    tick;
    chk("valid_drop", 32'(s_vld), 0);
  endtask

  task automatic finish_seq;
    chk("done_pulse", 32'(s_done), 1);
    chk("done_busy", 32'(s_busy), 0);
    tick;
    chk("done_clear", 32'(s_done), 0);
    chk("idle_prog_idx", 32'(s_idx), 0);
    chk("idle_core_rst", 32'(s_rst), 0);
  endtask

  initial begin
    int n;
    int rc;
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b1;
    go = 2'b00; ack = 2'b00; rdy = 2'b00; sel = 1'b0;
    repeat (3) tick;
    chk("rst_dutreset", 32'(s_rst), 1);
    chk("rst_dutstart", 32'(s_start), 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_done", 32'(s_done), 0);
    chk("rst_valid", 32'(s_vld), 0);
    chk("rst_idx", 32'(s_idx), 0);
    Reset = 1'b0;
    tick;
    chk("idle_dutreset", 32'(s_rst), 0);

    // Three programs, Ack in RUN cycles 10, 4, 7, ready always high.
    start_seq;
    run_one(0, 1'b0, 10, 0, 0, 10, 1'b0);
    run_one(1, 1'b0, 4, 0, 0, 4, 1'b0);
    run_one(2, 1'b0, 7, 0, 0, 7, 1'b0);
    finish_seq;

    // Stale Ack, watchdog at 20, stalled consumer with a stray Go during RUN.
    start_seq;
    run_one(0, 1'b1, 3, 0, 0, 3, 1'b0);
    run_one(1, 1'b0, 0, 0, 0, 20, 1'b1);
    run_one(2, 1'b0, 5, 2, 5, 5, 1'b0);
    finish_seq;

    // TIMEOUT=8 instance: Ack on the timeout cycle wins.
    sel = 1'b1;
    start_seq;
    run_one(0, 1'b0, 8, 0, 0, 8, 1'b0);
    run_one(1, 1'b0, 0, 0, 0, 8, 1'b1);
    run_one(2, 1'b0, 2, 0, 0, 2, 1'b0);
    finish_seq;

    // Reset during program 1 with counter at 5, then a clean restart.
    sel = 1'b0;
    start_seq;
    run_one(0, 1'b0, 3, 0, 0, 3, 1'b0);
    n = 0;
    while (s_start && n < 20) begin
      tick;
      n++;
    end
    chk("mid_start_len", n, 2);
    rc = 1;
    while (rc < 6) begin
      tick;
      rc++;
    end
    Reset = 1'b1;
    tick;
    chk("mid_rst_dutreset", 32'(s_rst), 1);
    chk("mid_rst_dutstart", 32'(s_start), 0);
    chk("mid_rst_busy", 32'(s_busy), 0);
    chk("mid_rst_valid", 32'(s_vld), 0);
    chk("mid_rst_idx", 32'(s_idx), 0);
    chk("mid_rst_cycles", 32'(s_cyc), 0);
    chk("mid_rst_prog", 32'(s_prog), 0);
    chk("mid_rst_timeout", 32'(s_to), 0);
    Reset = 1'b0;
    tick;
    chk("post_rst_dutreset", 32'(s_rst), 0);
    start_seq;
    run_one(0, 1'b0, 6, 0, 0, 6, 1'b0);
    run_one(1, 1'b0, 2, 0, 0, 2, 1'b0);
    run_one(2, 1'b0, 3, 0, 0, 3, 1'b0);
    finish_seq;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Upstream harness controller for the 9-bit processor core; drives the core's Reset and Start pins and consumes its Ack.
- Runs NUM_PROGS programs back-to-back: one core reset, then one Start pulse per program.
- Measures the cycles from Start release to Ack for each program, with a watchdog timeout.
- Each result is presented on a valid/ready port for a scoreboard or logger.

Parameters:
- NUM_PROGS, 3, number of programs run per Go; range 1..4.
- RESET_CYC, 2, cycles DutReset is held high before the first program; must be >= 1.
- START_CYC, 2, cycles DutStart is held high per program; must be >= 1.
- CW, 16, width of the cycle counter and of ResCycles.
- TIMEOUT, 50000, RUN-cycle limit per program; must be <= 2**CW-1.

Ports:
- Clk  input  1  clock, posedge.
- Reset  input  1  synchronous, active-high.
- Go  input  1  starts a run sequence; sampled only in IDLE.
- DutAck  input  1  done flag from the core.
- DutReset  output  1  registered reset to the core.
- DutStart  output  1  registered start to the core.
- ProgIdx  output  2  index of the current program (0-based).
- Busy  output  1  high from Go acceptance until Done.
- Done  output  1  one-cycle pulse after the last result is accepted.
- ResValid  output  1  result available.
- ResReady  input  1  consumer accepts the result.
- ResProg  output  2  program index of the result.
- ResCycles  output  CW  measured RUN cycles.
- ResTimeout  output  1  result ended by the watchdog, not by Ack.

Behaviour:
- Reset is synchronous and active-high on Clk. It applies in any state, including mid-run or mid-report.
  - State goes to IDLE.
  - DutReset=1, DutStart=0, Busy=0, Done=0, ResValid=0.
  - ProgIdx=0, ResProg=0, ResCycles=0, ResTimeout=0.
  - A pending result is discarded.
- IDLE: DutReset=0 from the first cycle after Reset deasserts. Go=1 moves to RST and sets Busy=1 in the next cycle.
- RST: DutReset=1 for exactly RESET_CYC cycles, then DutReset=0 and the state moves to START. ProgIdx=0.
- START: DutStart=1 for exactly START_CYC cycles, then DutStart=0 and the state moves to RUN.
  - The cycle counter is cleared to 0 on entry to RUN.
- RUN: the counter increments every RUN cycle.
  - DutAck is ignored in the first RUN cycle (stale-Ack mask).
  - From the second RUN cycle on, DutAck=1 accepts the result: ResCycles=counter+1 (RUN cycles inclusive), ResTimeout=0.
  - If counter+1 reaches TIMEOUT with no accepted Ack: ResCycles=TIMEOUT, ResTimeout=1.
  - When Ack and timeout occur in the same cycle, Ack wins (ResTimeout=0).
  - Either exit moves to REPORT, with ResValid=1 in the next cycle and ResProg=ProgIdx.
- REPORT: ResValid, ResProg, ResCycles and ResTimeout stay stable until the cycle where ResValid and ResReady are both 1.
  - After the transfer, ResValid=0 in the next cycle.
  - If ProgIdx < NUM_PROGS-1: ProgIdx increments and the state moves to START (no second core reset).
  - Otherwise the state moves to DONE.
- DONE: Done=1 for one cycle, Busy=0 in the same cycle, then IDLE. ProgIdx returns to 0.
- Go outside IDLE is ignored. A Go held high in IDLE after DONE starts a new sequence.
- DutAck outside RUN is ignored.
- ResReady outside REPORT has no effect.
- The counter never wraps, because TIMEOUT <= 2**CW-1.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset mid-RUN (program 1, counter=5): outputs equal reset values next cycle. Go issued afterwards restarts at ProgIdx=0 with a fresh RST phase.
- Go with NUM_PROGS=3, DutAck rising in RUN cycles 10, 4 and 7, ResReady tied 1:
  - DutReset high 2 cycles; DutStart high 2 cycles per program.
  - Results (0,10,0), (1,4,0), (2,7,0); Done pulses once; Busy falls with Done.
- DutAck held high through START and the first RUN cycle, then low, then high in RUN cycle 3: ResCycles=3 (stale Ack masked).
- TIMEOUT=20, DutAck stuck 0: ResCycles=20, ResTimeout=1. Sequencer proceeds to the next program.
- ResReady low for 5 cycles in REPORT: ResValid and data held constant; the next DutStart pulse begins only after the handshake.
- Go pulsed during RUN: ignored, sequence unchanged. Ack coincident with the timeout cycle (TIMEOUT=8, Ack in RUN cycle 8): ResTimeout=0, ResCycles=8.
